// File: rtl/c_reg_skid_v1_0.sv
// c_reg_skid_v1_0
// Elastic input stage for the C_WIDTH-bit output register of a baseblock pipeline.
// A valid/ready handshake feeds a registered output word. A single skid entry
// soaks up one cycle of downstream back-pressure, so the stage holds 0, 1 or 2 words.
//
// Handshake: a word moves on a rising CLK edge when its valid and ready are both 1.
//   Upstream:   in_xfer  = D_VALID & D_READY
//   Downstream: out_xfer = Q_VALID & Q_READY
//   D_READY and Q_VALID come from registers, gated only by CE. There is no
//   combinational path from D_VALID to Q_VALID, or from Q_READY to D_READY.
//
// Ports:
//   CLK        clock, rising edge
//   ACLR_N     asynchronous reset, active low; Q and skid load C_AINIT_VAL
//   CE         clock enable (used only when C_HAS_CE != 0); 0 freezes all state
//   SINIT      synchronous init (used only when C_HAS_SINIT != 0); overrides CE,
//              loads C_SINIT_VAL into Q and empties the stage
//   D          input data
//   D_VALID    input word valid
//   D_READY    stage can accept a word
//   Q          registered output data
//   Q_VALID    Q holds a valid word
//   Q_READY    downstream accepts Q
//   OCCUPANCY  number of words held (0, 1, 2)
//   state_dbg  current FSM state (EMPTY=0, BUSY=1, FULL=2)
//
// The init values are binary strings such as "1010". The rightmost character
// is bit 0, and a string shorter than C_WIDTH is zero-extended. An empty
// string means all zeros.
module c_reg_skid_v1_0 #(
    parameter int                   C_WIDTH     = 16,
    parameter logic [8*C_WIDTH-1:0] C_AINIT_VAL = "",
    parameter logic [8*C_WIDTH-1:0] C_SINIT_VAL = "",
    parameter int                   C_HAS_CE    = 0,
    parameter int                   C_HAS_SINIT = 0
) (
    input  logic               CLK,
    input  logic               ACLR_N,
    input  logic               CE,
    input  logic               SINIT,
    input  logic [C_WIDTH-1:0] D,
    input  logic               D_VALID,
    output logic               D_READY,
    output logic [C_WIDTH-1:0] Q,
    output logic               Q_VALID,
    input  logic               Q_READY,
    output logic [1:0]         OCCUPANCY,
    output logic [1:0]         state_dbg
);

    // A string literal is right-aligned in the packed parameter. Byte i holds
    // the character for bit i, and unused leading bytes are zero.
    function automatic logic [C_WIDTH-1:0] str_to_bits(input logic [8*C_WIDTH-1:0] s);
        logic [C_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < C_WIDTH; i++) begin
            v[i] = (s[8*i +: 8] == 8'h31);
        end
        return v;
    endfunction

    function automatic bit str_is_binary(input logic [8*C_WIDTH-1:0] s);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < C_WIDTH; i++) begin
            if (!((s[8*i +: 8] == 8'h30) || (s[8*i +: 8] == 8'h31) || (s[8*i +: 8] == 8'h00))) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    if (!str_is_binary(C_AINIT_VAL)) begin : g_bad_ainit
        $fatal(1, "c_reg_skid_v1_0: C_AINIT_VAL may contain only '0' and '1'");
    end
    if (!str_is_binary(C_SINIT_VAL)) begin : g_bad_sinit
        $fatal(1, "c_reg_skid_v1_0: C_SINIT_VAL may contain only '0' and '1'");
    end

    localparam logic [C_WIDTH-1:0] AIV = str_to_bits(C_AINIT_VAL);
    localparam logic [C_WIDTH-1:0] SIV = str_to_bits(C_SINIT_VAL);

    // The state encoding equals the number of words held.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state;
    logic               valid_reg;
    logic               ready_reg;
    logic [C_WIDTH-1:0] q_reg;
    logic [C_WIDTH-1:0] skid;

    logic               intCE;
    logic               intSINIT;
    logic               in_xfer;
    logic               out_xfer;
    logic [1:0]         occ_run;
    logic               load_q_d;
    logic               load_skid;
    logic               load_q_skid;
    logic [C_WIDTH-1:0] q_run;

    // CE and SINIT always appear in the logic, so an unused option simply folds away.
    assign intCE    = CE | (C_HAS_CE == 0);
    assign intSINIT = SINIT & (C_HAS_SINIT != 0);

    assign D_READY   = ready_reg & intCE;
    assign Q_VALID   = valid_reg & intCE;
    assign Q         = q_reg;
    assign OCCUPANCY = state;
    assign state_dbg = state;

    assign in_xfer  = D_VALID & D_READY;
    assign out_xfer = Q_VALID & Q_READY;

    // Word count after this edge when CE=1 and SINIT is inactive.
    assign occ_run = state + {1'b0, in_xfer} - {1'b0, out_xfer};

    // Q takes D when it is empty or is being drained in the same cycle. A word
    // that arrives while Q is stalled goes to skid. Skid refills Q when the
    // full stage is drained.
    assign load_q_d    = in_xfer & (~valid_reg | out_xfer);
    assign load_skid   = in_xfer & valid_reg & ~out_xfer;
    assign load_q_skid = out_xfer & ~ready_reg;
    assign q_run       = load_q_d ? D : (load_q_skid ? skid : q_reg);

    // Next-state selection uses conditional operators so that an X on a
    // handshake, CE or SINIT propagates into the state registers.
    always_ff @(posedge CLK or negedge ACLR_N) begin
        if (!ACLR_N) begin
            state     <= EMPTY;
            valid_reg <= 1'b0;
            ready_reg <= 1'b0;
            q_reg     <= AIV;
            skid      <= AIV;
        end else begin
            state     <= state_t'(intSINIT ? 2'd0 : (intCE ? occ_run : state));
            valid_reg <= intSINIT ? 1'b0 : (intCE ? (occ_run != 2'd0) : valid_reg);
            ready_reg <= intSINIT ? 1'b1 : (intCE ? (occ_run != 2'd2) : ready_reg);
            q_reg     <= intSINIT ? SIV  : (intCE ? q_run : q_reg);
            skid      <= (~intSINIT & intCE & load_skid) ? D : skid;
        end
    end

endmodule

// File: tb/tb_c_reg_skid_v1_0.sv
// Testbench for c_reg_skid_v1_0.
// The reference model holds the stored words in a queue:
//   D_READY = armed & CE & (fewer than 2 words held)
//   Q_VALID = CE & (at least 1 word held)
//   Q       = oldest word held, or otherwise the last value shown.
// A separate scoreboard checks the end-to-end FIFO order of delivered words.
module tb_c_reg_skid_v1_0;

    localparam int W = 16;
    localparam logic [W-1:0] AIV = 16'hAAAA;
    localparam logic [W-1:0] SIV = 16'h00FF;

    // ---------------- clock / reset ----------------
    logic         CLK     = 1'b0;
    logic         ACLR_N  = 1'b0;
    logic         CE      = 1'b1;
    logic         SINIT   = 1'b0;
    logic [W-1:0] D       = '0;
    logic         D_VALID = 1'b0;
    logic         Q_READY = 1'b0;
    logic         D_READY;
    logic [W-1:0] Q;
    logic         Q_VALID;
    logic [1:0]   OCCUPANCY;
    logic [1:0]   state_dbg;

    always #5 CLK = ~CLK;

    c_reg_skid_v1_0 #(
        .C_WIDTH    (W),
        .C_AINIT_VAL("1010101010101010"),
        .C_SINIT_VAL("0000000011111111"),
        .C_HAS_CE   (1),
        .C_HAS_SINIT(1)
    ) dut (
        .CLK      (CLK),
        .ACLR_N   (ACLR_N),
        .CE       (CE),
        .SINIT    (SINIT),
        .D        (D),
        .D_VALID  (D_VALID),
        .D_READY  (D_READY),
        .Q        (Q),
        .Q_VALID  (Q_VALID),
        .Q_READY  (Q_READY),
        .OCCUPANCY(OCCUPANCY),
        .state_dbg(state_dbg)
    );

    // ---------------- model + scoreboard ----------------
    logic [W-1:0] held[$];
    logic [W-1:0] exp_q[$];
    bit           armed;
    logic [W-1:0] q_shown;
    int           n_checks = 0;
    int           n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    endtask

    task automatic model_reset();
        held.delete();
        exp_q.delete();
        armed   = 1'b0;
        q_shown = AIV;
    endtask

    function automatic bit model_dready();
        return armed && CE && (held.size() < 2);
    endfunction

    function automatic bit model_qvalid();
        return CE && (held.size() > 0);
    endfunction

    task automatic check_outputs();
        check("d_ready",   {31'b0, D_READY}, {31'b0, model_dready()});
        check("q_valid",   {31'b0, Q_VALID}, {31'b0, model_qvalid()});
        check("occupancy", {30'b0, OCCUPANCY}, held.size());
        check("q",         {16'b0, Q}, {16'b0, (held.size() > 0) ? held[0] : q_shown});
    endtask

    // ---------------- driver ----------------
    // Inputs are driven on the falling edge. Outputs are checked 1 ns later,
    // and then the model advances on the rising edge.
    task automatic step(input bit dv, input logic [W-1:0] d, input bit qr, input bit ce, input bit si);
        bit exp_in;
        bit exp_out;
        @(negedge CLK);
        D_VALID = dv;
        D       = d;
        Q_READY = qr;
        CE      = ce;
        SINIT   = si;
        #1;
        check_outputs();
        exp_in  = ACLR_N && model_dready() && dv;
        exp_out = ACLR_N && model_qvalid() && qr;
        if (ACLR_N && !si) begin
            if (Q_VALID && Q_READY) begin
                if (exp_q.size() == 0) check("sb_unexpected_word", {31'b0, Q_VALID}, 32'd0);
                else check("sb_data", {16'b0, Q}, {16'b0, exp_q.pop_front()});
            end
            if (D_VALID && D_READY) exp_q.push_back(D);
        end
        @(posedge CLK);
        if (!ACLR_N) begin
            model_reset();
        end else if (si) begin
            held.delete();
            exp_q.delete();
            q_shown = SIV;
            armed   = 1'b1;
        end else if (ce) begin
            if (exp_out) void'(held.pop_front());
            if (exp_in) held.push_back(d);
            armed = 1'b1;
            if (held.size() > 0) q_shown = held[0];
        end
    endtask

    task automatic release_reset();
        #1 ACLR_N = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        // Reset / ready
        ACLR_N = 1'b0;
        repeat (3) step(0, '0, 0, 1, 0);
        release_reset();
        step(1, 16'h1111, 1, 1, 0);      // first edge: the word must not be captured
        // Streaming
        for (int i = 1; i <= 4; i++) step(1, W'(i), 1, 1, 0);
        step(0, '0, 1, 1, 0);
        step(0, '0, 1, 1, 0);
        // Back-pressure
        step(1, 16'd5, 0, 1, 0);
        step(1, 16'd6, 0, 1, 0);
        step(1, 16'd7, 0, 1, 0);         // FULL: 7 refused
        // CE stall while FULL
        repeat (4) step(1, 16'd8, 1, 0, 0);
        step(1, 16'd7, 1, 1, 0);
        step(1, 16'd7, 1, 1, 0);
        step(0, '0, 1, 1, 0);
        step(0, '0, 1, 1, 0);
        // SINIT flush from FULL, with CE=0 and a coincident input word
        step(1, 16'h21, 0, 1, 0);
        step(1, 16'h22, 0, 1, 0);
        step(1, 16'h23, 0, 0, 1);
        step(0, '0, 0, 1, 0);
        step(0, '0, 1, 1, 0);
        // Async reset in the middle of a cycle
        step(1, 16'd9, 0, 1, 0);
        step(0, '0, 0, 1, 0);
        @(negedge CLK);
        #2 ACLR_N = 1'b0;
        #1;
        model_reset();
        check_outputs();
        step(0, '0, 0, 1, 0);
        release_reset();
        // Random traffic
        for (int n = 0; n < 600; n++) begin
            step(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) != 0), ($urandom_range(0, 39) == 0));
        end
        // Drain
        repeat (4) step(0, '0, 1, 1, 0);
        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
